// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encodings and the fixed iteration count.
package mul16_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MUL_ITER = 16;

endpackage

// File: rtl/mul16_seq_add16bit.sv
// 16-bit ripple-carry adder shared by every partial-product step of mul16_seq.
module add16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        co
);

    logic [16:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        for (int i = 0; i < 16; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[16];
    end

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier: one shift-and-add step per clock through
// a single shared add16bit, with valid/ready handshakes on operands and product.
import mul16_seq_pkg::*;

module mul16_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     sum;
    logic                 co;
    logic [2*WIDTH-1:0]   step;

    add16bit u_add (
        .a  (prod_q[2*WIDTH-1:WIDTH]),
        .b  (m_q),
        .s  (sum),
        .co (co)
    );

    // Add step: carry-out lands in the top bit; otherwise a plain right shift.
    assign step = prod_q[0] ? {co, sum, prod_q[WIDTH-1:1]}
                            : {1'b0, prod_q[2*WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    prod_d  = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        p_d     = step;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prod_q  <= '0;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign p         = p_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: stimulus pushes expected products, a monitor
// pops and compares on every result handshake.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] p;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [15:0] ra, rb;
    logic        sdone = 1'b0;
    int          n;

    mul16_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", p);
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", p, mon_exp);
            end
        end
    end

    task automatic do_accept(input logic [15:0] ta, input logic [15:0] tb,
                             input bit push, input logic [31:0] exp);
        int k;
        k = 0;
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=%0d required=accept", k);
        end else if (push) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic run_directed(input string name, input logic [15:0] ta,
                                input logic [15:0] tb, input logic [31:0] exp);
        int lat;
        do_accept(ta, tb, 1'b1, exp);
        check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'd16);
        @(posedge clk);
        #1;
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({name, "_out_valid_low"}, 32'(out_valid), 32'd0);
        check({name, "_p_kept"}, p, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", p, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        run_directed("3x5", 16'd3, 16'd5, 32'h0000000F);
        run_directed("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_directed("1234x0", 16'h1234, 16'h0000, 32'h00000000);
        run_directed("0xabcd", 16'h0000, 16'hABCD, 32'h00000000);
        run_directed("8000x2", 16'h8000, 16'h0002, 32'h00010000);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        do_accept(16'd7, 16'd9, 1'b1, 32'h0000003F);
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd16);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                a = 16'h5555;
                b = 16'h0003;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_p", p, 32'h0000003F);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Abort mid-RUN: no result may appear.
        do_accept(16'd100, 16'd200, 1'b0, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("abort_quiet", 32'(out_valid), 32'd0);
        run_directed("100x200", 16'd100, 16'd200, 32'h00004E20);

        // Asynchronous reset mid-RUN, checked before any further clock edge.
        do_accept(16'd100, 16'd200, 1'b0, 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_p", p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random back-to-back traffic with consumer stalls.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    do_accept(ra, rb, 1'b1, {16'd0, ra} * {16'd0, rb});
                end
                sdone = 1'b1;
            end
            begin
                while (!sdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
